phy_prbs_test_ctrl: RTL and testbench

Self-test sequencer for the 10G PHY loopback path. On `start` it resets the PHY, enables the PRBS31 generator and checker, and waits for `rx_block_lock`. It then lets the link settle and accumulates `rx_error_count` over a fixed measurement window. It reports pass/fail, a fail code and the total error count. It sits beside `eth_phy_10g` and drives that block's resets and PRBS config inputs.

---
 rtl/phy_prbs_test_pkg.sv | 35 +++
 rtl/phy_prbs_test_if.sv | 39 +++
 rtl/phy_prbs_test_ctrl_sat_accum.sv | 39 +++
 rtl/phy_prbs_test_ctrl.sv | 167 ++++++++++++++++
 tb/tb_phy_prbs_test_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/phy_prbs_test_pkg.sv
// Shared types and constants for the PHY PRBS31 self-test sequencer.
package phy_prbs_test_pkg;

  // Width of the per-cycle PRBS bit-error count reported by the PHY.
  localparam int RX_ERR_W = 7;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_MEASURE   = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  // Fail codes reported on fail_code.
  localparam logic [2:0] FAIL_NONE      = 3'd0;
  localparam logic [2:0] FAIL_LOCK_TMO  = 3'd1;
  localparam logic [2:0] FAIL_LOCK_LOST = 3'd2;
  localparam logic [2:0] FAIL_HIGH_BER  = 3'd3;
  localparam logic [2:0] FAIL_ERR_THR   = 3'd4;
  localparam logic [2:0] FAIL_ABORTED   = 3'd5;

  // Largest of four durations; sizes the shared cycle counter.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/phy_prbs_test_if.sv
// Control/status bundle between the self-test sequencer and its user/PHY.
interface phy_prbs_test_if #(
  parameter int CNT_WIDTH = 32
);
  import phy_prbs_test_pkg::*;

  // Run control and PHY status
  logic                 start;
  logic                 abort;
  logic                 rx_block_lock;
  logic                 rx_high_ber;
  logic [RX_ERR_W-1:0]  rx_error_count;

  // PHY control and test result
  logic                 phy_tx_rst;
  logic                 phy_rx_rst;
  logic                 cfg_tx_prbs31_enable;
  logic                 cfg_rx_prbs31_enable;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [2:0]           fail_code;
  logic [CNT_WIDTH-1:0] err_total;

  // Controller / PHY-model side
  modport master (
    output start, abort, rx_block_lock, rx_high_ber, rx_error_count,
    input  phy_tx_rst, phy_rx_rst, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable,
    input  busy, done, pass, fail_code, err_total
  );

  // Sequencer side
  modport slave (
    input  start, abort, rx_block_lock, rx_high_ber, rx_error_count,
    output phy_tx_rst, phy_rx_rst, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable,
    output busy, done, pass, fail_code, err_total
  );

endinterface

// File: rtl/phy_prbs_test_ctrl_sat_accum.sv
// Saturating accumulator: adds a zero-extended input each enabled cycle and
// sticks at all-ones instead of wrapping. Also exposes the would-be next sum so
// the caller can make decisions on the value that includes the current sample.
module sat_accum #(
  parameter int WIDTH    = 32,
  parameter int IN_WIDTH = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [IN_WIDTH-1:0] val_i,
  output logic [WIDTH-1:0]    sum_o,
  output logic [WIDTH-1:0]    sum_next_o
);

  logic [WIDTH-1:0] sum_q;
  logic [WIDTH:0]   sum_wide;

  // One extra bit catches the carry; any carry means the sum saturated.
  always_comb begin
    sum_wide   = {1'b0, sum_q} + (WIDTH + 1)'(val_i);
    sum_next_o = sum_wide[WIDTH] ? {WIDTH{1'b1}} : sum_wide[WIDTH-1:0];
  end

  // Accumulator register; clear wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (clr_i) begin
      sum_q <= '0;
    end else if (en_i) begin
      sum_q <= sum_next_o;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/phy_prbs_test_ctrl.sv
// PRBS31 loopback self-test sequencer for the 10G PHY: resets the PHY, enables
// the PRBS generator/checker, waits for block lock, lets the link settle, then
// accumulates bit errors over a fixed window and reports pass/fail.
module phy_prbs_test_ctrl
  import phy_prbs_test_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int SETTLE_CYCLES = 64,
  parameter int WINDOW_CYCLES = 1024,
  parameter int ERR_THRESHOLD = 0,
  parameter int CNT_WIDTH     = 32
) (
  input logic            clk,
  input logic            rst,
  phy_prbs_test_if.slave bus
);

  // One counter serves every timed state, so size it for the longest one.
  localparam int MAX_CYC = max4(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES, WINDOW_CYCLES);
  localparam int CYC_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CYC_W-1:0]     RST_LAST    = CYC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0]     LOCK_LAST   = CYC_W'(LOCK_TIMEOUT - 1);
  localparam logic [CYC_W-1:0]     SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0]     WINDOW_LAST = CYC_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ERR_THR     = CNT_WIDTH'(ERR_THRESHOLD);

  state_e               state_q, state_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic                 pass_q, pass_d;
  logic [2:0]           code_q, code_d;

  logic                 busy;
  logic                 start_ok;
  logic                 accum_clr;
  logic                 accum_en;
  logic [CNT_WIDTH-1:0] err_sum;
  logic [CNT_WIDTH-1:0] err_sum_next;

  assign busy      = (state_q == ST_RESET) || (state_q == ST_WAIT_LOCK) ||
                     (state_q == ST_SETTLE) || (state_q == ST_MEASURE);
  assign start_ok  = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign accum_clr = start_ok;
  // An abort preempts the cycle entirely, so its sample is not counted.
  assign accum_en  = (state_q == ST_MEASURE) && !bus.abort;

  sat_accum #(
    .WIDTH    (CNT_WIDTH),
    .IN_WIDTH (RX_ERR_W)
  ) u_err_accum (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (accum_clr),
    .en_i       (accum_en),
    .val_i      (bus.rx_error_count),
    .sum_o      (err_sum),
    .sum_next_o (err_sum_next)
  );

  // Next-state, cycle counter and result logic.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    pass_d  = pass_q;
    code_d  = code_q;

    if (busy && bus.abort) begin
      state_d = ST_DONE;
      pass_d  = 1'b0;
      code_d  = FAIL_ABORTED;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_d = ST_RESET;
            cyc_d   = '0;
            pass_d  = 1'b0;
            code_d  = FAIL_NONE;
          end
        end
        ST_RESET: begin
          if (cyc_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cyc_d   = '0;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (bus.rx_block_lock) begin
            state_d = ST_SETTLE;
            cyc_d   = '0;
          end else if (cyc_q == LOCK_LAST) begin
            state_d = ST_DONE;
            code_d  = FAIL_LOCK_TMO;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (!bus.rx_block_lock) begin
            state_d = ST_DONE;
            code_d  = FAIL_LOCK_LOST;
          end else if (cyc_q == SETTLE_LAST) begin
            state_d = ST_MEASURE;
            cyc_d   = '0;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        ST_MEASURE: begin
          // Lock loss outranks high BER; both outrank the window end.
          if (!bus.rx_block_lock) begin
            state_d = ST_DONE;
            code_d  = FAIL_LOCK_LOST;
          end else if (bus.rx_high_ber) begin
            state_d = ST_DONE;
            code_d  = FAIL_HIGH_BER;
          end else if (cyc_q == WINDOW_LAST) begin
            // Judge on the sum that already includes this cycle's sample.
            state_d = ST_DONE;
            if (err_sum_next <= ERR_THR) begin
              pass_d = 1'b1;
              code_d = FAIL_NONE;
            end else begin
              pass_d = 1'b0;
              code_d = FAIL_ERR_THR;
            end
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      pass_q  <= 1'b0;
      code_q  <= FAIL_NONE;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      pass_q  <= pass_d;
      code_q  <= code_d;
    end
  end

  // PRBS stays enabled through reset and lock acquisition as well as the measurement.
  assign bus.phy_tx_rst           = (state_q == ST_RESET);
  assign bus.phy_rx_rst           = (state_q == ST_RESET);
  assign bus.cfg_tx_prbs31_enable = busy;
  assign bus.cfg_rx_prbs31_enable = busy;
  assign bus.busy                 = busy;
  assign bus.done                 = (state_q == ST_DONE);
  assign bus.pass                 = pass_q;
  assign bus.fail_code            = code_q;
  assign bus.err_total            = err_sum;

endmodule

// File: tb/tb_phy_prbs_test_ctrl.sv
// Directed test of the PRBS self-test sequencer. Three instances share one
// stimulus: 0 = threshold 0 / 32-bit total, 1 = threshold 15, 2 = 8-bit total.
module tb_phy_prbs_test_ctrl;
  import phy_prbs_test_pkg::*;

  logic clk;
  logic rst;
  logic start;
  logic abort;
  logic lock;
  logic ber;
  logic [RX_ERR_W-1:0] errc;

  logic [2:0]  busy_o, done_o, pass_o, txrst_o, rxrst_o, txprbs_o, rxprbs_o;
  logic [2:0]  code_o [3];
  logic [31:0] err_o  [3];

  int checks   = 0;
  int failures = 0;
  int n;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam int THR = (gi == 1) ? 15 : 0;
      localparam int CW  = (gi == 2) ? 8 : 32;

      phy_prbs_test_if #(.CNT_WIDTH(CW)) bus ();

      assign bus.start          = start;
      assign bus.abort          = abort;
      assign bus.rx_block_lock  = lock;
      assign bus.rx_high_ber    = ber;
      assign bus.rx_error_count = errc;

      assign busy_o[gi]   = bus.busy;
      assign done_o[gi]   = bus.done;
      assign pass_o[gi]   = bus.pass;
      assign txrst_o[gi]  = bus.phy_tx_rst;
      assign rxrst_o[gi]  = bus.phy_rx_rst;
      assign txprbs_o[gi] = bus.cfg_tx_prbs31_enable;
      assign rxprbs_o[gi] = bus.cfg_rx_prbs31_enable;
      assign code_o[gi]   = bus.fail_code;
      assign err_o[gi]    = 32'(bus.err_total);

      phy_prbs_test_ctrl #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (64),
        .SETTLE_CYCLES (8),
        .WINDOW_CYCLES (32),
        .ERR_THRESHOLD (THR),
        .CNT_WIDTH     (CW)
      ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s got=%0d", tag, got);
    end
  endtask

  // Steps until instance 0 reports done or the budget runs out.
  task automatic wait_done(input int limit, output int cnt);
    cnt = 0;
    while (!done_o[0] && cnt < limit) begin
      step(1);
      cnt++;
    end
  endtask

  // Pulses start with lock already high; returns sampling in the first MEASURE cycle.
  task automatic run_to_measure();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(13);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; lock = 1'b0; ber = 1'b0; errc = '0;
    step(3);
    rst = 1'b0;
    step(1);

    // Reset state
    check("rst_busy",  busy_o[0],   0);
    check("rst_done",  done_o[0],   0);
    check("rst_pass",  pass_o[0],   0);
    check("rst_code",  code_o[0],   0);
    check("rst_err",   err_o[0],    0);
    check("rst_txrst", txrst_o[0],  0);
    check("rst_prbs",  rxprbs_o[0], 0);

    // 1: clean loopback
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("t1_busy",   busy_o[0],   1);
    check("t1_rxrst",  rxrst_o[0],  1);
    check("t1_txprbs", txprbs_o[0], 1);
    n = 0;
    while (txrst_o[0] && n < 20) begin
      n++;
      step(1);
    end
    check("t1_rst_len",   n,           4);
    check("t1_wl_rst",    txrst_o[0],  0);
    check("t1_wl_prbs",   rxprbs_o[0], 1);
    lock = 1'b1;
    wait_done(100, n);
    check("t1_len",       n,           41);
    check("t1_done",      done_o[0],   1);
    check("t1_pass",      pass_o[0],   1);
    check("t1_code",      code_o[0],   FAIL_NONE);
    check("t1_err",       err_o[0],    0);
    check("t1_done_prbs", txprbs_o[0], 0);
    check("t1_done_busy", busy_o[0],   0);

    // 2: lock never arrives
    lock = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("t2_done_clr", done_o[0], 0);
    check("t2_pass_clr", pass_o[0], 0);
    wait_done(200, n);
    check("t2_len",  n,         68);
    check("t2_pass", pass_o[0], 0);
    check("t2_code", code_o[0], FAIL_LOCK_TMO);

    // 3: five cycles of 3 errors; a start pulse mid-run must be ignored
    lock = 1'b1;
    run_to_measure();
    check("t3_meas_busy", busy_o[0], 1);
    errc = 7'd3;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    errc = '0;
    check("t3_err_mid", err_o[0], 15);
    wait_done(100, n);
    check("t3_len",    n,         27);
    check("t3_code0",  code_o[0], FAIL_ERR_THR);
    check("t3_pass0",  pass_o[0], 0);
    check("t3_err0",   err_o[0],  15);
    check("t3_pass1",  pass_o[1], 1);
    check("t3_code1",  code_o[1], FAIL_NONE);
    check("t3_err1",   err_o[1],  15);
    check("t3_code2",  code_o[2], FAIL_ERR_THR);

    // 4: lock loss and high BER together; last sample still counted
    run_to_measure();
    errc = 7'd1;
    step(2);
    errc = 7'd5;
    lock = 1'b0;
    ber = 1'b1;
    step(1);
    check("t4_done",   done_o[0], 1);
    check("t4_code",   code_o[0], FAIL_LOCK_LOST);
    check("t4_err",    err_o[0],  7);
    step(3);
    check("t4_frozen", err_o[0],  7);
    lock = 1'b1;
    ber = 1'b0;
    errc = '0;

    // 4b: high BER alone
    run_to_measure();
    ber = 1'b1;
    step(1);
    ber = 1'b0;
    check("t4b_done", done_o[0], 1);
    check("t4b_code", code_o[0], FAIL_HIGH_BER);

    // 5: 66 errors per cycle; 8-bit total saturates
    run_to_measure();
    errc = 7'd66;
    wait_done(100, n);
    errc = '0;
    check("t5_len",   n,         32);
    check("t5_err0",  err_o[0],  2112);
    check("t5_code0", code_o[0], FAIL_ERR_THR);
    check("t5_err2",  err_o[2],  255);
    check("t5_code2", code_o[2], FAIL_ERR_THR);

    // 6: abort in WAIT_LOCK
    lock = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    check("t6_wl_busy", busy_o[0], 1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("t6_done", done_o[0], 1);
    check("t6_code", code_o[0], FAIL_ABORTED);
    check("t6_pass", pass_o[0], 0);

    // 6b: abort in DONE ignored, simultaneous start honoured
    lock = 1'b1;
    abort = 1'b1;
    start = 1'b1;
    step(1);
    abort = 1'b0;
    start = 1'b0;
    check("t6b_busy", busy_o[0], 1);
    check("t6b_code", code_o[0], FAIL_NONE);

    // 6c: rst in MEASURE
    step(13);
    errc = 7'd2;
    step(2);
    check("t6c_err_pre", err_o[0], 4);
    rst = 1'b1;
    step(1);
    errc = '0;
    check("t6c_busy",  busy_o[0],   0);
    check("t6c_done",  done_o[0],   0);
    check("t6c_err",   err_o[0],    0);
    check("t6c_txrst", txrst_o[0],  0);
    check("t6c_prbs",  txprbs_o[0], 0);
    check("t6c_code",  code_o[0],   0);
    rst = 1'b0;

    // 6d: fresh run after reset
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done(100, n);
    check("t6d_len",  n,         45);
    check("t6d_pass", pass_o[0], 1);
    check("t6d_code", code_o[0], FAIL_NONE);
    check("t6d_err",  err_o[0],  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
